dcache: RTL and testbench

- Small direct-mapped, write-through, no-write-allocate data cache between the core's data port and a word-wide memory bus.
- Accepts byte, half and word loads and stores from the core.
- Performs lane alignment, store byte strobes and load sign/zero extension.
- Returns a single-cycle dcache_valid pulse per access.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_if.sv | 46 ++++
 rtl/dcache_align.sv | 48 ++++
 rtl/dcache.sv | 219 +++++++++++++++++++++
 tb/tb_dcache.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
package dcache_pkg;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_RFILL,
      S_WTHRU,
      S_RESP
   } state_t;

   // Index width for a given number of one-word lines.
   function automatic int calc_idx(input int lines);
      return $clog2(lines);
   endfunction

   // Tag width: word address bits left over after the index.
   function automatic int calc_tag(input int lines);
      return 30 - $clog2(lines);
   endfunction

endpackage

// File: rtl/dcache_if.sv
// Core-side and memory-side buses of the data cache.

// Core data port: the core is master, the cache is slave.
interface dcache_core_if;
   logic        dcache_r_ena;
   logic        dcache_w_ena;
   logic        dcache_ext;
   logic [1:0]  dcache_width;
   logic [31:0] dcache_addr;
   logic [31:0] dcache_data_in;
   logic        dcache_valid;
   logic [31:0] dcache_data_out;

   modport master (
      output dcache_r_ena, dcache_w_ena, dcache_ext, dcache_width,
             dcache_addr, dcache_data_in,
      input  dcache_valid, dcache_data_out
   );

   modport slave (
      input  dcache_r_ena, dcache_w_ena, dcache_ext, dcache_width,
             dcache_addr, dcache_data_in,
      output dcache_valid, dcache_data_out
   );
endinterface

// Word-wide memory bus: the cache is master, memory is slave.
interface dcache_mem_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/dcache_align.sv
// Lane steering: store strobes/replication and load extraction/extension.
module dcache_align
   import dcache_pkg::*;
(
   input  logic [1:0]  width,
   input  logic        ext,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] rd_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] ld_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Pick the addressed lane, then shape strobes, write data and load data by width.
   always_comb begin
      case (addr_lo)
         2'd0:    sel_byte = rd_word[7:0];
         2'd1:    sel_byte = rd_word[15:8];
         2'd2:    sel_byte = rd_word[23:16];
         default: sel_byte = rd_word[31:24];
      endcase
      sel_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

      // Word behaviour is the baseline; width 11 falls through to it.
      wstrb   = 4'b1111;
      wdata   = st_data;
      ld_data = rd_word;

      case (width)
         W_BYTE: begin
            wstrb   = 4'b0001 << addr_lo;
            wdata   = {4{st_data[7:0]}};
            ld_data = {{24{ext & sel_byte[7]}}, sel_byte};
         end
         W_HALF: begin
            wstrb   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{st_data[15:0]}};
            ld_data = {{16{ext & sel_half[15]}}, sel_half};
         end
         W_WORD, 2'b11: ;
      endcase
   end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a load/store; request fields are latched on entry
// S_LOOKUP | tag compare; load hit responds, else a memory request issues
// S_RFILL  | load miss outstanding; on ack the line is filled and data sent
// S_WTHRU  | store write-through outstanding; line never allocated here
// S_RESP   | dcache_valid pulse, back to idle
module dcache
   import dcache_pkg::*;
#(
   parameter int LINES = 64
) (
   input  logic         clk,
   input  logic         rst,
   dcache_core_if.slave core,
   dcache_mem_if.master mem
);

   localparam int IDX = calc_idx(LINES);
   localparam int TAG = calc_tag(LINES);

   state_t            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [1:0]        width_q, width_d;
   logic              ext_q, ext_d;
   logic [31:0]       st_data_q, st_data_d;
   logic              store_q, store_d;
   logic [LINES-1:0]  line_vld_q, line_vld_d;

   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              valid_q, valid_d;
   logic [31:0]       data_out_q, data_out_d;

   logic [TAG-1:0]    tag_arr [LINES];
   logic [31:0]       data_arr [LINES];

   logic [IDX-1:0]    idx;
   logic [TAG-1:0]    tag;
   logic              hit;
   logic [31:0]       rd_word;
   logic [31:0]       merged;
   logic [3:0]        al_wstrb;
   logic [31:0]       al_wdata;
   logic [31:0]       al_ld;
   logic              arr_we;
   logic [31:0]       arr_wdata;

   assign idx = addr_q[IDX+1:2];
   assign tag = addr_q[31:IDX+2];
   assign hit = line_vld_q[idx] && (tag_arr[idx] == tag);

   // The fill path extracts straight from the returning bus word.
   assign rd_word = (state_q == S_RFILL) ? mem.mem_rdata : data_arr[idx];

   dcache_align u_align (
      .width   (width_q),
      .ext     (ext_q),
      .addr_lo (addr_q[1:0]),
      .st_data (st_data_q),
      .rd_word (rd_word),
      .wstrb   (al_wstrb),
      .wdata   (al_wdata),
      .ld_data (al_ld)
   );

   // Store-hit merge of the aligned write data into the cached word.
   always_comb begin
      merged = data_arr[idx];
      for (int i = 0; i < 4; i++) begin
         if (al_wstrb[i]) begin
            merged[8*i +: 8] = al_wdata[8*i +: 8];
         end
      end
   end

   // Next-state and registered-output logic of the controller.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      width_d     = width_q;
      ext_d       = ext_q;
      st_data_d   = st_data_q;
      store_d     = store_q;
      line_vld_d  = line_vld_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      valid_d     = 1'b0;
      data_out_d  = '0;
      arr_we      = 1'b0;
      arr_wdata   = merged;

      case (state_q)
         S_IDLE: begin
            if (core.dcache_r_ena || core.dcache_w_ena) begin
               addr_d    = core.dcache_addr;
               width_d   = core.dcache_width;
               ext_d     = core.dcache_ext;
               st_data_d = core.dcache_data_in;
               // A simultaneous load+store request is a store.
               store_d   = core.dcache_w_ena;
               state_d   = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (store_q) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {addr_q[31:2], 2'b00};
               mem_wstrb_d = al_wstrb;
               mem_wdata_d = al_wdata;
               arr_we      = hit;
               state_d     = S_WTHRU;
            end else if (hit) begin
               valid_d    = 1'b1;
               data_out_d = al_ld;
               state_d    = S_RESP;
            end else begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = {addr_q[31:2], 2'b00};
               mem_wstrb_d = '0;
               mem_wdata_d = '0;
               state_d     = S_RFILL;
            end
         end
         S_RFILL: begin
            if (mem.mem_ack) begin
               arr_we          = 1'b1;
               arr_wdata       = mem.mem_rdata;
               line_vld_d[idx] = 1'b1;
               mem_req_d       = 1'b0;
               mem_we_d        = 1'b0;
               mem_addr_d      = '0;
               valid_d         = 1'b1;
               data_out_d      = al_ld;
               state_d         = S_RESP;
            end
         end
         S_WTHRU: begin
            if (mem.mem_ack) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wstrb_d = '0;
               mem_wdata_d = '0;
               valid_d     = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Controller state and bus outputs; reset abandons any transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         width_q     <= '0;
         ext_q       <= 1'b0;
         st_data_q   <= '0;
         store_q     <= 1'b0;
         line_vld_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wstrb_q <= '0;
         mem_wdata_q <= '0;
         valid_q     <= 1'b0;
         data_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         width_q     <= width_d;
         ext_q       <= ext_d;
         st_data_q   <= st_data_d;
         store_q     <= store_d;
         line_vld_q  <= line_vld_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         valid_q     <= valid_d;
         data_out_q  <= data_out_d;
      end
   end

   // Tag and data arrays; contents are qualified by the valid bits only.
   always_ff @(posedge clk) begin
      if (arr_we) begin
         tag_arr[idx]  <= tag;
         data_arr[idx] <= arr_wdata;
      end
   end

   assign core.dcache_valid    = valid_q;
   assign core.dcache_data_out = data_out_q;
   assign mem.mem_req          = mem_req_q;
   assign mem.mem_we           = mem_we_q;
   assign mem.mem_addr         = mem_addr_q;
   assign mem.mem_wstrb        = mem_wstrb_q;
   assign mem.mem_wdata        = mem_wdata_q;

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: directed accesses, memory responder, monitor.
module tb_dcache;

   logic clk;
   logic rst;

   dcache_core_if core_bus ();
   dcache_mem_if  mem_bus ();

   dcache #(.LINES(64)) dut (
      .clk  (clk),
      .rst  (rst),
      .core (core_bus),
      .mem  (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } mexp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          req_count = 0;
   int          mem_delay = 0;

   logic [31:0] exp_q [$];
   string       name_q [$];
   mexp_t       mexp_q [$];
   logic [31:0] mem_model [logic [31:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected load result per dcache_valid pulse.
   initial begin
      logic [31:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         if (core_bus.dcache_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected dcache_valid: got 1 expected 0");
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               chk(nm, core_bus.dcache_data_out, e);
            end
         end else begin
            chk("data_out while not valid", core_bus.dcache_data_out, 32'h0);
         end
      end
   end

   // Memory responder: checks each request, holds it mem_delay cycles, then acks.
   initial begin
      logic        busy;
      int          wait_cnt;
      mexp_t       snap;
      mexp_t       m;
      logic [31:0] word;
      busy = 1'b0;
      wait_cnt = 0;
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy = 1'b0;
            mem_bus.mem_ack = 1'b0;
         end else if (mem_bus.mem_ack) begin
            mem_bus.mem_ack = 1'b0;
            busy = 1'b0;
            chk("mem_req drop after ack", {31'h0, mem_bus.mem_req}, 32'h0);
         end else if (mem_bus.mem_req) begin
            if (!busy) begin
               busy = 1'b1;
               wait_cnt = 0;
               req_count++;
               snap.we    = mem_bus.mem_we;
               snap.addr  = mem_bus.mem_addr;
               snap.strb  = mem_bus.mem_wstrb;
               snap.wdata = mem_bus.mem_wdata;
               if (mexp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected mem_req: addr %h expected no request", mem_bus.mem_addr);
               end else begin
                  m = mexp_q.pop_front();
                  chk("mem_we", {31'h0, mem_bus.mem_we}, {31'h0, m.we});
                  chk("mem_addr", mem_bus.mem_addr, m.addr);
                  if (m.we) begin
                     chk("mem_wstrb", {28'h0, mem_bus.mem_wstrb}, {28'h0, m.strb});
                     chk("mem_wdata", mem_bus.mem_wdata, m.wdata);
                  end
               end
            end else begin
               chk("mem outputs stable", {31'h0, (mem_bus.mem_we === snap.we) &&
                   (mem_bus.mem_addr === snap.addr) && (mem_bus.mem_wstrb === snap.strb) &&
                   (mem_bus.mem_wdata === snap.wdata)}, 32'h1);
            end
            if (wait_cnt >= mem_delay) begin
               mem_bus.mem_ack = 1'b1;
               word = mem_model.exists(snap.addr) ? mem_model[snap.addr] : 32'h0;
               if (snap.we) begin
                  for (int i = 0; i < 4; i++) begin
                     if (snap.strb[i]) word[8*i +: 8] = snap.wdata[8*i +: 8];
                  end
                  mem_model[snap.addr] = word;
               end else begin
                  mem_bus.mem_rdata = word;
               end
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // One core access; the memory transaction expectation is pushed only when one is due.
   task automatic access(input string name, input bit rd, input bit wr,
                         input logic [1:0] w, input bit ext, input logic [31:0] a,
                         input logic [31:0] d, input int dly, input logic [31:0] exp_data,
                         input bit exp_mem, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata);
      int    c0;
      int    lat;
      bit    seen;
      mexp_t m;
      exp_q.push_back(exp_data);
      name_q.push_back(name);
      if (exp_mem) begin
         m.we    = wr;
         m.addr  = {a[31:2], 2'b00};
         m.strb  = exp_strb;
         m.wdata = exp_wdata;
         mexp_q.push_back(m);
      end
      mem_delay = dly;
      c0 = req_count;
      @(negedge clk);
      core_bus.dcache_r_ena   = rd;
      core_bus.dcache_w_ena   = wr;
      core_bus.dcache_width   = w;
      core_bus.dcache_ext     = ext;
      core_bus.dcache_addr    = a;
      core_bus.dcache_data_in = d;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (core_bus.dcache_valid) seen = 1'b1;
      end
      core_bus.dcache_r_ena = 1'b0;
      core_bus.dcache_w_ena = 1'b0;
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: got no dcache_valid expected a pulse within 60 cycles", name);
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
      end
      chk({name, " mem requests"}, req_count - c0, exp_mem ? 32'd1 : 32'd0);
      if (!exp_mem) chk({name, " hit latency"}, lat, 32'd2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen_req;
      mexp_t m;
      mem_model[32'h100] = 32'hDEADBEEF;
      mem_model[32'h200] = 32'h8081F0F1;
      mem_model[32'h300] = 32'h11223344;
      mem_model[32'h500] = 32'hCAFEF00D;

      rst = 1'b0;
      core_bus.dcache_r_ena   = 1'b0;
      core_bus.dcache_w_ena   = 1'b0;
      core_bus.dcache_width   = 2'b00;
      core_bus.dcache_ext     = 1'b0;
      core_bus.dcache_addr    = 32'h0;
      core_bus.dcache_data_in = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset dcache_valid", {31'h0, core_bus.dcache_valid}, 32'h0);
      chk("reset mem_req", {31'h0, mem_bus.mem_req}, 32'h0);
      chk("reset mem_we", {31'h0, mem_bus.mem_we}, 32'h0);
      chk("reset mem_addr", mem_bus.mem_addr, 32'h0);
      chk("reset mem_wstrb", {28'h0, mem_bus.mem_wstrb}, 32'h0);
      chk("reset mem_wdata", mem_bus.mem_wdata, 32'h0);
      rst = 1'b1;
      @(negedge clk);

      //     name                 rd wr width  ext addr          data_in       dly exp_data      mem strb     wdata
      access("ldw 100 miss",       1, 0, 2'b10, 0, 32'h100, 32'h0,        3, 32'hDEADBEEF, 1, 4'h0, 32'h0);
      access("ldw 100 hit",        1, 0, 2'b10, 0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 0, 4'h0, 32'h0);
      access("ldw 200 alias miss", 1, 0, 2'b10, 0, 32'h200, 32'h0,        1, 32'h8081F0F1, 1, 4'h0, 32'h0);
      access("ldw 100 re-miss",    1, 0, 2'b10, 0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 1, 4'h0, 32'h0);
      access("ldw 200 miss",       1, 0, 2'b10, 0, 32'h200, 32'h0,        2, 32'h8081F0F1, 1, 4'h0, 32'h0);
      access("ldb 202 sext",       1, 0, 2'b00, 1, 32'h202, 32'h0,        0, 32'hFFFFFF81, 0, 4'h0, 32'h0);
      access("ldb 202 zext",       1, 0, 2'b00, 0, 32'h202, 32'h0,        0, 32'h00000081, 0, 4'h0, 32'h0);
      access("ldh 202 sext",       1, 0, 2'b01, 1, 32'h202, 32'h0,        0, 32'hFFFF8081, 0, 4'h0, 32'h0);
      access("ldh 200 zext",       1, 0, 2'b01, 0, 32'h200, 32'h0,        0, 32'h0000F0F1, 0, 4'h0, 32'h0);
      access("ldh 203 sext",       1, 0, 2'b01, 1, 32'h203, 32'h0,        0, 32'hFFFF8081, 0, 4'h0, 32'h0);
      access("ldb 203 sext",       1, 0, 2'b00, 1, 32'h203, 32'h0,        0, 32'hFFFFFF80, 0, 4'h0, 32'h0);
      access("ldb 200 sext",       1, 0, 2'b00, 1, 32'h200, 32'h0,        0, 32'hFFFFFFF1, 0, 4'h0, 32'h0);
      access("stb 201 hit",        0, 1, 2'b00, 0, 32'h201, 32'h123456AB, 1, 32'h0,        1, 4'b0010, 32'hABABABAB);
      access("ldw 200 merged b",   1, 0, 2'b10, 0, 32'h200, 32'h0,        0, 32'h8081ABF1, 0, 4'h0, 32'h0);
      access("sth 202 hit",        0, 1, 2'b01, 0, 32'h202, 32'h5555BEEF, 0, 32'h0,        1, 4'b1100, 32'hBEEFBEEF);
      access("ldw 200 merged h",   1, 0, 2'b10, 0, 32'h200, 32'h0,        0, 32'hBEEFABF1, 0, 4'h0, 32'h0);
      access("stw 300 miss w11",   0, 1, 2'b11, 0, 32'h300, 32'hA5A5C3C3, 2, 32'h0,        1, 4'b1111, 32'hA5A5C3C3);
      access("ldw 200 no alloc",   1, 0, 2'b10, 0, 32'h200, 32'h0,        0, 32'hBEEFABF1, 0, 4'h0, 32'h0);
      access("ldw 300 miss",       1, 0, 2'b10, 0, 32'h300, 32'h0,        1, 32'hA5A5C3C3, 1, 4'h0, 32'h0);
      access("rw 300 as store",    1, 1, 2'b00, 1, 32'h300, 32'h00000077, 0, 32'h0,        1, 4'b0001, 32'h77777777);
      access("ldw 300 merged",     1, 0, 2'b10, 0, 32'h300, 32'h0,        0, 32'hA5A5C377, 0, 4'h0, 32'h0);

      // Reset while a fill is outstanding: request dies, no valid pulse.
      m.we = 1'b0; m.addr = 32'h500; m.strb = 4'h0; m.wdata = 32'h0;
      mexp_q.push_back(m);
      mem_delay = 20;
      @(negedge clk);
      core_bus.dcache_r_ena = 1'b1;
      core_bus.dcache_width = 2'b10;
      core_bus.dcache_addr  = 32'h500;
      seen_req = 1'b0;
      for (int i = 0; i < 10 && !seen_req; i++) begin
         @(negedge clk);
         if (mem_bus.mem_req) seen_req = 1'b1;
      end
      chk("rfill mem_req seen", {31'h0, seen_req}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async reset mem_req", {31'h0, mem_bus.mem_req}, 32'h0);
      chk("async reset valid", {31'h0, core_bus.dcache_valid}, 32'h0);
      core_bus.dcache_r_ena = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      access("ldw 300 after rst",  1, 0, 2'b10, 0, 32'h300, 32'h0,        0, 32'hA5A5C377, 1, 4'h0, 32'h0);
      access("ldb 501 after rst",  1, 0, 2'b00, 1, 32'h501, 32'h0,        2, 32'hFFFFFFF0, 1, 4'h0, 32'h0);
      access("ldh 500 zext hit",   1, 0, 2'b01, 0, 32'h500, 32'h0,        0, 32'h0000F00D, 0, 4'h0, 32'h0);
      access("ldw 503 hit",        1, 0, 2'b10, 1, 32'h503, 32'h0,        0, 32'hCAFEF00D, 0, 4'h0, 32'h0);

      repeat (4) @(negedge clk);
      chk("pending load results", exp_q.size(), 32'h0);
      chk("pending mem requests", mexp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
